// File: rtl/speaker_serializer_if.sv
// speaker_serializer_if
// Bundles the sample inputs and DAC-side outputs of speaker_serializer.
//   master : sample source (drives audio_left/audio_right[/mute], observes DAC pins)
//   slave  : the serializer (reads samples, drives mclk/sck/lrck/sdin/sample_req)
// Optional: SPK_MUTE_EN adds the mute signal.
interface speaker_serializer_if;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
`ifdef SPK_MUTE_EN
  logic        mute;
`endif
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        audio_sdin;
  logic        sample_req;

  modport master (
`ifdef SPK_MUTE_EN
    output mute,
`endif
    output audio_left, audio_right,
    input  audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req
  );

  modport slave (
`ifdef SPK_MUTE_EN
    input  mute,
`endif
    input  audio_left, audio_right,
    output audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req
  );
endinterface

// File: rtl/speaker_serializer.sv
// speaker_serializer
// Serialises 16-bit stereo samples into a left-justified stream for the board
// audio DAC and generates the DAC clocks from clk.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   bus     speaker_serializer_if.slave (samples in, DAC pins out)
// Parameters:
//   MCLK_SHIFT  audio_mclk = div_cnt[MCLK_SHIFT]   (0 <= MCLK_SHIFT < SCK_SHIFT)
//   SCK_SHIFT   audio_sck  = div_cnt[SCK_SHIFT]; one bit slot = 2^(SCK_SHIFT+1) clk
// Frame = 32 slots = 2^(SCK_SHIFT+6) clk. Samples are latched into shadow
// registers only at the frame wrap, so upstream changes never tear a word.
// Optional: define SPK_MUTE_EN to add a mute input that loads zeros at the wrap.
module speaker_serializer #(
  parameter int MCLK_SHIFT = 1,
  parameter int SCK_SHIFT  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  speaker_serializer_if.slave   bus
);

  localparam int              CNT_W   = SCK_SHIFT + 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [15:0]      shadow_l_q, shadow_l_d;
  logic [15:0]      shadow_r_q, shadow_r_d;
  logic             mclk_q, mclk_d;
  logic             sck_q, sck_d;
  logic             lrck_q, lrck_d;
  logic             sdin_q, sdin_d;
  logic             req_q, req_d;
  logic             wrap;
  logic [4:0]       slot_d;
  logic [3:0]       bit_idx;

  // Outputs are registered from next-state values so that each output in a
  // given cycle matches that cycle's counter and shadow contents, with no lag.
  always_comb begin
    div_cnt_d  = div_cnt_q + 1'b1;
    wrap       = (div_cnt_q == CNT_MAX);
    shadow_l_d = shadow_l_q;
    shadow_r_d = shadow_r_q;
    if (wrap) begin
`ifdef SPK_MUTE_EN
      shadow_l_d = bus.mute ? 16'h0000 : bus.audio_left;
      shadow_r_d = bus.mute ? 16'h0000 : bus.audio_right;
`else
      shadow_l_d = bus.audio_left;
      shadow_r_d = bus.audio_right;
`endif
    end

    slot_d  = div_cnt_d[CNT_W-1 -: 5];
    // 15-slot for the left word and 31-slot for the right word both reduce
    // to the inverted low four slot bits.
    bit_idx = ~slot_d[3:0];
    sdin_d  = slot_d[4] ? shadow_r_d[bit_idx] : shadow_l_d[bit_idx];

    mclk_d  = div_cnt_d[MCLK_SHIFT];
    sck_d   = div_cnt_d[SCK_SHIFT];
    lrck_d  = div_cnt_d[CNT_W-1];
    req_d   = (div_cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      shadow_l_q <= '0;
      shadow_r_q <= '0;
      mclk_q     <= 1'b0;
      sck_q      <= 1'b0;
      lrck_q     <= 1'b0;
      sdin_q     <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      shadow_l_q <= shadow_l_d;
      shadow_r_q <= shadow_r_d;
      mclk_q     <= mclk_d;
      sck_q      <= sck_d;
      lrck_q     <= lrck_d;
      sdin_q     <= sdin_d;
      req_q      <= req_d;
    end
  end

  assign bus.audio_mclk = mclk_q;
  assign bus.audio_sck  = sck_q;
  assign bus.audio_lrck = lrck_q;
  assign bus.audio_sdin = sdin_q;
  assign bus.sample_req = req_q;

endmodule

// File: tb/tb_speaker_serializer.sv
module tb_speaker_serializer;

  localparam int FRAME = 512;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  bit   chk_en;

  // reference model state: position within frame and the words being sent
  int          m_pos;
  logic [15:0] m_sl;
  logic [15:0] m_sr;

  speaker_serializer_if bus();

  speaker_serializer #(.MCLK_SHIFT(1), .SCK_SHIFT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t pos=%0d)", tag, obs, exp_v, $time, m_pos);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= 0;
      m_sl  <= '0;
      m_sr  <= '0;
    end else begin
      if (m_pos == FRAME - 1) begin
`ifdef SPK_MUTE_EN
        m_sl <= bus.mute ? 16'h0000 : bus.audio_left;
        m_sr <= bus.mute ? 16'h0000 : bus.audio_right;
`else
        m_sl <= bus.audio_left;
        m_sr <= bus.audio_right;
`endif
      end
      m_pos <= (m_pos + 1) % FRAME;
    end
  end

  // Per-cycle comparison of every DAC pin against the frame-position model.
  always @(negedge clk) begin
    int slot;
    logic e_sdin;
    if (chk_en) begin
      slot   = m_pos / 16;
      e_sdin = (slot < 16) ? m_sl[15 - slot] : m_sr[31 - slot];
      chk("mclk", bus.audio_mclk, 32'((m_pos / 2) % 2));
      chk("sck",  bus.audio_sck,  32'((m_pos / 8) % 2));
      chk("lrck", bus.audio_lrck, 32'(m_pos >= FRAME / 2));
      chk("sdin", bus.audio_sdin, 32'(e_sdin));
      chk("req",  bus.sample_req, 32'(m_pos == FRAME - 1));
    end
  end

  task automatic wait_frame_start();
    int n;
    n = 0;
    while (m_pos != 0 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1100) chk("sync_timeout", 32'(m_pos), 32'd0);
  endtask

  // mode 0: no stimulus; 1: audio_left=chg_val at chg_pos;
  // 2: audio_left=C000 only at pos 511, 3FFF otherwise; 3: mute=chg_val[0] at chg_pos
  task automatic run_frame(input int mode, input int chg_pos, input logic [15:0] chg_val,
                           output logic [15:0] wl, output logic [15:0] wr);
    int   req_n, req_at, lr_hi, sck_r, mclk_r, slot;
    logic p_sck, p_mclk;
    wait_frame_start();
    wl = '0; wr = '0;
    req_n = 0; req_at = -1; lr_hi = 0; sck_r = 0; mclk_r = 0;
    p_sck  = bus.audio_sck;
    p_mclk = bus.audio_mclk;
    for (int i = 0; i < FRAME; i++) begin
      case (mode)
        1: if (m_pos == chg_pos) bus.audio_left = chg_val;
        2: bus.audio_left = (m_pos == FRAME - 1) ? 16'hC000 : 16'h3FFF;
`ifdef SPK_MUTE_EN
        3: if (m_pos == chg_pos) bus.mute = chg_val[0];
`endif
        default: ;
      endcase
      if (bus.audio_sck && !p_sck) begin
        sck_r++;
        slot = i / 16;
        if (slot < 16) wl[15 - slot] = bus.audio_sdin;
        else           wr[31 - slot] = bus.audio_sdin;
      end
      if (bus.audio_mclk && !p_mclk) mclk_r++;
      if (bus.sample_req) begin
        req_n++;
        req_at = i;
      end
      if (bus.audio_lrck) lr_hi++;
      p_sck  = bus.audio_sck;
      p_mclk = bus.audio_mclk;
      @(negedge clk);
    end
    chk("req_count",  32'(req_n),  32'd1);
    chk("req_pos",    32'(req_at), 32'd511);
    chk("lrck_high",  32'(lr_hi),  32'd256);
    chk("sck_rises",  32'(sck_r),  32'd32);
    chk("mclk_rises", 32'(mclk_r), 32'd128);
  endtask

  initial begin
    logic [15:0] wl, wr;
    n_chk  = 0;
    n_fail = 0;
    chk_en = 1'b0;
    rst_n  = 1'b1;
    bus.audio_left  = 16'hA5C3;
    bus.audio_right = 16'h3C5A;
`ifdef SPK_MUTE_EN
    bus.mute = 1'b0;
`endif
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mclk", bus.audio_mclk, 32'd0);
    chk("rst_lrck", bus.audio_lrck, 32'd0);
    chk("rst_sdin", bus.audio_sdin, 32'd0);
    chk("rst_req",  bus.sample_req, 32'd0);
    rst_n = 1'b1;

    run_frame(0, -1, 16'h0, wl, wr);
    chk("f0_left", wl, 16'h0000);
    chk("f0_right", wr, 16'h0000);
    run_frame(1, 0, 16'h1234, wl, wr);
    chk("f1_left", wl, 16'hA5C3);
    chk("f1_right", wr, 16'h3C5A);

    // mid-frame change must not touch the word in flight
    run_frame(1, 100, 16'hFFFF, wl, wr);
    chk("mid_cur", wl, 16'h1234);
    run_frame(0, -1, 16'h0, wl, wr);
    chk("mid_next", wl, 16'hFFFF);

    // value present only on the wrap cycle is the one captured
    run_frame(2, -1, 16'h0, wl, wr);
    chk("wrap_prev", wl, 16'hFFFF);
    run_frame(1, 0, 16'h3FFF, wl, wr);
    chk("wrap_cap", wl, 16'hC000);
    chk("wrap_right", wr, 16'h3C5A);

    // asynchronous reset mid-frame
    bus.audio_left  = 16'h5555;
    bus.audio_right = 16'h8000;
    wait_frame_start();
    repeat (300) @(negedge clk);
    chk("pre_rst_lrck", bus.audio_lrck, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mclk", bus.audio_mclk, 32'd0);
    chk("arst_sck",  bus.audio_sck,  32'd0);
    chk("arst_lrck", bus.audio_lrck, 32'd0);
    chk("arst_sdin", bus.audio_sdin, 32'd0);
    chk("arst_req",  bus.sample_req, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, -1, 16'h0, wl, wr);
    chk("post_rst_l", wl, 16'h0000);
    chk("post_rst_r", wr, 16'h0000);
    run_frame(1, 0, 16'h7FFF, wl, wr);
    chk("post_rst_l2", wl, 16'h5555);
    chk("post_rst_r2", wr, 16'h8000);

`ifdef SPK_MUTE_EN
    run_frame(3, 50, 16'h1, wl, wr);
    chk("mute_cur", wl, 16'h7FFF);
    run_frame(3, 200, 16'h0, wl, wr);
    chk("mute_next", wl, 16'h0000);
    chk("mute_next_r", wr, 16'h0000);
    run_frame(0, -1, 16'h0, wl, wr);
    chk("unmute", wl, 16'h7FFF);
`else
    run_frame(0, -1, 16'h0, wl, wr);
    chk("edge_val", wl, 16'h7FFF);
`endif

    // randomized traffic, checked cycle by cycle against the model
    for (int f = 0; f < 6; f++) begin
`ifdef SPK_MUTE_EN
      bus.mute = ($urandom_range(0, 3) == 0);
`endif
      for (int i = 0; i < FRAME; i++) begin
        if ($urandom_range(0, 31) == 0) bus.audio_left  = 16'($urandom);
        if ($urandom_range(0, 31) == 0) bus.audio_right = 16'($urandom);
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
